snake_dir_sched: RTL

Sequences player direction commands into the game logic and owns the game run/pause/over phases. It sits between the joystick debouncers and game_logic. It replaces the direct button-to-direction mapping with a validated command queue: at most one queued turn is released per game update tick. Reversals and duplicate turns are filtered, and button input is ignored outside the RUN phase.

---
 rtl/snake_pkg.sv | 20 ++
 rtl/snake_dir_sched_fifo.sv | 79 +++++++
 rtl/snake_dir_sched.sv | 132 +++++++++++++
 3 files changed

// File: rtl/snake_pkg.sv
// Shared direction and phase encodings for the snake direction scheduler.
// Direction codes: 00 up, 01 right, 10 down, 11 left.
package snake_pkg;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_DOWN  = 2'b10;
  localparam logic [1:0] DIR_LEFT  = 2'b11;

  localparam logic [1:0] PH_IDLE  = 2'b00;
  localparam logic [1:0] PH_RUN   = 2'b01;
  localparam logic [1:0] PH_PAUSE = 2'b10;
  localparam logic [1:0] PH_OVER  = 2'b11;

  // Opposite heading differs only in the vertical/horizontal sense bit.
  function automatic logic [1:0] dir_reverse(input logic [1:0] c);
    return c ^ 2'b10;
  endfunction

endpackage

// File: rtl/snake_dir_sched_fifo.sv
// Small circular queue of 2-bit turn codes with head/tail peek.
// A push into a full queue succeeds when a pop happens in the same cycle.
module dir_fifo
  import snake_pkg::*;
#(
  parameter int QDEPTH = 4,
  localparam int PTR_W = $clog2(QDEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [1:0]       din,
  output logic [1:0]       head,
  output logic [1:0]       tail,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [1:0]       mem_q [QDEPTH];
  logic [1:0]       mem_d [QDEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] tail_ptr;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(QDEPTH));
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign tail_ptr = wr_ptr_q - PTR_W'(1);
  assign head     = mem_q[rd_ptr_q];
  assign tail     = mem_q[tail_ptr];
  assign count    = count_q;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Storage is data only; emptiness is defined by the pointers and count.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
    mem_q <= mem_d;
  end

endmodule

// File: rtl/snake_dir_sched.sv
// Turns debounced joystick presses into validated, tick-paced direction
// commits for game_logic, and owns the IDLE/RUN/PAUSE/OVER phase machine.
module snake_dir_sched
  import snake_pkg::*;
#(
  parameter int         QDEPTH   = 4,
  parameter logic [1:0] DIR_INIT = 2'b01,
  localparam int        CNT_W    = $clog2(QDEPTH) + 1
) (
  input  logic             vga_clk,
  input  logic             reset,
  input  logic [3:0]       btn_dn,
  input  logic             start_dn,
  input  logic             upd_tick,
  input  logic             game_over,
  output logic [1:0]       direction,
  output logic             dir_upd,
  output logic             run,
  output logic [1:0]       phase,
  output logic [CNT_W-1:0] q_count,
  output logic             q_ovf
);

  // Simultaneous presses resolve to the lowest index.
  function automatic logic [1:0] first_press(input logic [3:0] b);
    if (b[0])      return DIR_UP;
    else if (b[1]) return DIR_RIGHT;
    else if (b[2]) return DIR_DOWN;
    else           return DIR_LEFT;
  endfunction

  logic [1:0] phase_q, phase_d;
  logic [1:0] dir_q, dir_d;
  logic       dir_upd_q, dir_upd_d;
  logic       q_ovf_q, q_ovf_d;

  logic       in_run;
  logic       start_game;
  logic       q_flush;
  logic       press_vld;
  logic [1:0] cand;
  logic [1:0] ref_dir;
  logic       cand_ok;
  logic       push_req, pop_req;
  logic [1:0] q_head, q_tail;
  logic       q_full, q_empty;

  assign in_run     = (phase_q == PH_RUN);
  assign press_vld  = |btn_dn;
  assign cand       = first_press(btn_dn);
  assign ref_dir    = q_empty ? dir_q : q_tail;
  assign cand_ok    = in_run && press_vld &&
                      (cand != ref_dir) && (cand != dir_reverse(ref_dir));
  assign pop_req    = in_run && upd_tick && !q_empty;
  assign push_req   = cand_ok && (!q_full || pop_req);

  always_comb begin
    phase_d    = phase_q;
    start_game = 1'b0;
    q_flush    = 1'b0;
    case (phase_q)
      PH_IDLE: begin
        if (start_dn) begin
          phase_d    = PH_RUN;
          start_game = 1'b1;
          q_flush    = 1'b1;
        end
      end
      PH_RUN: begin
        if (game_over)     phase_d = PH_OVER;
        else if (start_dn) phase_d = PH_PAUSE;
      end
      PH_PAUSE: begin
        if (start_dn) phase_d = PH_RUN;
      end
      default: begin
        if (start_dn) begin
          phase_d = PH_IDLE;
          q_flush = 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    dir_d     = dir_q;
    dir_upd_d = pop_req;
    q_ovf_d   = cand_ok && q_full && !pop_req;
    if (start_game) begin
      dir_d = DIR_INIT;
    end else if (pop_req) begin
      dir_d = q_head;
    end
  end

  dir_fifo #(
    .QDEPTH (QDEPTH)
  ) u_fifo (
    .clk   (vga_clk),
    .rst   (reset),
    .flush (q_flush),
    .push  (push_req),
    .pop   (pop_req),
    .din   (cand),
    .head  (q_head),
    .tail  (q_tail),
    .count (q_count),
    .full  (q_full),
    .empty (q_empty)
  );

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      phase_q   <= PH_IDLE;
      dir_q     <= DIR_INIT;
      dir_upd_q <= 1'b0;
      q_ovf_q   <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      dir_q     <= dir_d;
      dir_upd_q <= dir_upd_d;
      q_ovf_q   <= q_ovf_d;
    end
  end

  assign phase     = phase_q;
  assign run       = (phase_q == PH_RUN);
  assign direction = dir_q;
  assign dir_upd   = dir_upd_q;
  assign q_ovf     = q_ovf_q;

endmodule
